// File: rtl/eth_phy_speed_detect_pkg.sv
// Shared speed codes and measurement result encoding for the PHY speed detector.
package eth_speed_pkg;

   localparam logic [1:0] SPEED_10M   = 2'b00;
   localparam logic [1:0] SPEED_100M  = 2'b01;
   localparam logic [1:0] SPEED_1000M = 2'b10;

   // Result codes reuse the speed codes; the spare code marks "no result this cycle".
   typedef enum logic [1:0] {
      RES_10M   = SPEED_10M,
      RES_100M  = SPEED_100M,
      RES_1000M = SPEED_1000M,
      RES_NONE  = 2'b11
   } result_e;

   // MII (as opposed to GMII) is used for every speed below gigabit.
   function automatic logic is_mii(input logic [1:0] spd);
      return spd != SPEED_1000M;
   endfunction

endpackage

// File: rtl/eth_phy_speed_detect_sync_edge.sv
// Synchroniser for the prescaled rx clock bit plus a registered any-edge pulse.
module eth_speed_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_edge
);

   // Top bit is the history flop; the bits below it form the synchroniser chain.
   (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
   logic [SYNC_STAGES:0] r_sync;
   (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
   logic                 r_edge;

   // Shift the async bit in and flag any change between the last two flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_edge <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-1:0], i_async};
         r_edge <= r_sync[SYNC_STAGES] ^ r_sync[SYNC_STAGES-1];
      end
   end

   assign o_edge = r_edge;

endmodule

// File: rtl/eth_phy_speed_detect.sv
// Classifies the PHY link as 10M/100M/1000M by counting prescaled rx clock edges
// against a reference window, with hysteresis and clock-absent detection.
module eth_phy_speed_detect
   import eth_speed_pkg::*;
#(
   parameter int         REF_WIDTH     = 7,
   parameter int         EDGE_WIDTH    = 2,
   parameter int         THRESH_100M   = 32,
   parameter int         HYST_COUNT    = 2,
   parameter int         NOCLK_WINDOWS = 4,
   parameter int         SYNC_STAGES   = 2,
   parameter logic [1:0] DEFAULT_SPEED = 2'b10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       rx_prescale,
   output logic [1:0] speed,
   output logic       mii_select,
   output logic       speed_valid,
   output logic       speed_change,
   output logic       rx_clk_present
);

   if (THRESH_100M >= (2 ** REF_WIDTH)) begin : g_bad_thresh
      $error("THRESH_100M must be below 2**REF_WIDTH");
   end
   if (HYST_COUNT < 1) begin : g_bad_hyst
      $error("HYST_COUNT must be at least 1");
   end
   if (NOCLK_WINDOWS < 1) begin : g_bad_noclk
      $error("NOCLK_WINDOWS must be at least 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end

   localparam int HC_W = $clog2(HYST_COUNT + 1);
   localparam int NC_W = $clog2(NOCLK_WINDOWS + 1);

   localparam logic [REF_WIDTH-1:0] THRESH_C = REF_WIDTH'(THRESH_100M);
   localparam logic [HC_W-1:0]      HYST_C   = HC_W'(HYST_COUNT);
   localparam logic [NC_W-1:0]      NOCLK_C  = NC_W'(NOCLK_WINDOWS);

   logic                  w_edge;
   logic                  w_edge_full;
   logic                  w_ref_full;
   logic                  w_meas_end;
   logic                  w_zero_win;
   result_e               w_result;
   logic [HC_W-1:0]       w_cand_cnt_nxt;
   logic [NC_W-1:0]       w_noclk_nxt;

   logic [REF_WIDTH-1:0]  r_ref_cnt;
   logic [EDGE_WIDTH-1:0] r_edge_cnt;
   logic [NC_W-1:0]       r_noclk_cnt;
   result_e               r_cand;
   logic [HC_W-1:0]       r_cand_cnt;
   logic [1:0]            r_speed;
   logic                  r_mii_select;
   logic                  r_speed_valid;
   logic                  r_speed_change;
   logic                  r_rx_clk_present;

   eth_speed_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_async(rx_prescale),
      .o_edge (w_edge)
   );

   // Decide whether this cycle ends a measurement and what it yielded.
   always_comb begin
      w_edge_full = &r_edge_cnt;
      w_ref_full  = &r_ref_cnt;
      w_meas_end  = w_edge_full | w_ref_full;
      w_result    = RES_NONE;
      w_zero_win  = 1'b0;
      if (w_edge_full) begin
         w_result = (r_ref_cnt >= THRESH_C) ? RES_100M : RES_1000M;
      end else if (w_ref_full) begin
         if (r_edge_cnt != '0) begin
            w_result = RES_10M;
         end else begin
            w_zero_win = 1'b1;
         end
      end
      if (w_result == r_cand) begin
         w_cand_cnt_nxt = (r_cand_cnt == HYST_C) ? HYST_C : r_cand_cnt + HC_W'(1);
      end else begin
         w_cand_cnt_nxt = HC_W'(1);
      end
      w_noclk_nxt = (r_noclk_cnt == NOCLK_C) ? NOCLK_C : r_noclk_cnt + NC_W'(1);
   end

   // Measurement counters, hysteresis candidate and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ref_cnt        <= '0;
         r_edge_cnt       <= '0;
         r_noclk_cnt      <= '0;
         r_cand           <= RES_10M;
         r_cand_cnt       <= '0;
         r_speed          <= DEFAULT_SPEED;
         r_mii_select     <= is_mii(DEFAULT_SPEED);
         r_speed_valid    <= 1'b0;
         r_speed_change   <= 1'b0;
         r_rx_clk_present <= 1'b0;
      end else if (!enable) begin
         r_ref_cnt      <= '0;
         r_edge_cnt     <= '0;
         r_noclk_cnt    <= '0;
         r_cand         <= RES_10M;
         r_cand_cnt     <= '0;
         r_speed_change <= 1'b0;
      end else begin
         r_speed_change <= 1'b0;
         // An edge landing in the end cycle is dropped with the cleared counts.
         if (w_meas_end) begin
            r_ref_cnt  <= '0;
            r_edge_cnt <= '0;
         end else begin
            r_ref_cnt <= r_ref_cnt + REF_WIDTH'(1);
            if (w_edge) begin
               r_edge_cnt <= r_edge_cnt + EDGE_WIDTH'(1);
            end
         end
         if (w_result != RES_NONE) begin
            r_noclk_cnt <= '0;
            r_cand      <= w_result;
            r_cand_cnt  <= w_cand_cnt_nxt;
            if (w_cand_cnt_nxt == HYST_C) begin
               r_speed          <= w_result;
               r_mii_select     <= is_mii(w_result);
               r_speed_valid    <= 1'b1;
               r_rx_clk_present <= 1'b1;
               r_speed_change   <= (w_result != r_speed);
            end
         end else if (w_zero_win) begin
            r_noclk_cnt <= w_noclk_nxt;
            // Clock lost: keep the last speed but force a fresh lock later.
            if (w_noclk_nxt == NOCLK_C) begin
               r_rx_clk_present <= 1'b0;
               r_speed_valid    <= 1'b0;
               r_cand           <= RES_10M;
               r_cand_cnt       <= '0;
            end
         end
      end
   end

   assign speed          = r_speed;
   assign mii_select     = r_mii_select;
   assign speed_valid    = r_speed_valid;
   assign speed_change   = r_speed_change;
   assign rx_clk_present = r_rx_clk_present;

endmodule
